lc4_reorder_buffer: RTL and testbench



---
 rtl/lc4_reorder_buffer_if.sv | 67 ++++++
 rtl/lc4_reorder_buffer.sv | 129 ++++++++++++
 tb/tb_lc4_reorder_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc4_reorder_buffer_if.sv
// Bundle of dispatch, issue, completion, flush, per-entry export and retire
// signals for the four-entry LC4 reorder buffer.
interface lc4_reorder_buffer_if;
    logic        gwe;
    // dispatch
    logic        ds_valid;
    logic [15:0] ds_insn;
    logic [15:0] ds_pc;
    logic [15:0] ds_pc_pred;
    logic [3:0]  ds_pr1;
    logic [3:0]  ds_pr2;
    logic [3:0]  ds_prd;
    logic        ds_stall;
    // issue / complete / flush events
    logic        is_valid;
    logic [1:0]  is_rob_index;
    logic        cm_valid;
    logic [1:0]  cm_rob_index;
    logic        fl_valid;
    logic [1:0]  fl_rob_index;
    // per-entry export
    logic [15:0] iq0_insn, iq1_insn, iq2_insn, iq3_insn;
    logic [15:0] iq0_pc, iq1_pc, iq2_pc, iq3_pc;
    logic [15:0] iq0_pc_pred, iq1_pc_pred, iq2_pc_pred, iq3_pc_pred;
    logic [3:0]  iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1;
    logic [3:0]  iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2;
    logic [3:0]  iq0_prd, iq1_prd, iq2_prd, iq3_prd;
    logic [3:0]  iq_valid;
    logic [3:0]  iq_issue;
    logic [3:0]  iq_commit;
    logic [1:0]  iq_rd;
    logic [2:0]  iq_count;
    // retire
    logic        rt_valid;
    logic [15:0] rt_insn;
    logic [15:0] rt_pc;
    logic [3:0]  rt_prd;
    logic [1:0]  rt_rob_index;

    modport master (
        output gwe, ds_valid, ds_insn, ds_pc, ds_pc_pred, ds_pr1, ds_pr2, ds_prd,
               is_valid, is_rob_index, cm_valid, cm_rob_index, fl_valid, fl_rob_index,
        input  ds_stall,
               iq0_insn, iq1_insn, iq2_insn, iq3_insn,
               iq0_pc, iq1_pc, iq2_pc, iq3_pc,
               iq0_pc_pred, iq1_pc_pred, iq2_pc_pred, iq3_pc_pred,
               iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1,
               iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2,
               iq0_prd, iq1_prd, iq2_prd, iq3_prd,
               iq_valid, iq_issue, iq_commit, iq_rd, iq_count,
               rt_valid, rt_insn, rt_pc, rt_prd, rt_rob_index
    );

    modport slave (
        input  gwe, ds_valid, ds_insn, ds_pc, ds_pc_pred, ds_pr1, ds_pr2, ds_prd,
               is_valid, is_rob_index, cm_valid, cm_rob_index, fl_valid, fl_rob_index,
        output ds_stall,
               iq0_insn, iq1_insn, iq2_insn, iq3_insn,
               iq0_pc, iq1_pc, iq2_pc, iq3_pc,
               iq0_pc_pred, iq1_pc_pred, iq2_pc_pred, iq3_pc_pred,
               iq0_pr1, iq1_pr1, iq2_pr1, iq3_pr1,
               iq0_pr2, iq1_pr2, iq2_pr2, iq3_pr2,
               iq0_prd, iq1_prd, iq2_prd, iq3_prd,
               iq_valid, iq_issue, iq_commit, iq_rd, iq_count,
               rt_valid, rt_insn, rt_pc, rt_prd, rt_rob_index
    );
endinterface

// File: rtl/lc4_reorder_buffer.sv
// Four-entry in-order reorder buffer feeding the LC4 issue stage. Entries are
// allocated at the tail, marked issued/completed in place, retired from the
// head, and squashed younger-than-mispredict on a flush.
module lc4_reorder_buffer (
    input  logic                 clk,
    input  logic                 rst,
    lc4_reorder_buffer_if.slave  rob
);
    logic [1:0]  r_head, r_tail;
    logic [2:0]  r_count;
    logic [3:0]  r_valid, r_issue, r_commit;
    logic [15:0] r_insn    [4];
    logic [15:0] r_pc      [4];
    logic [15:0] r_pc_pred [4];
    logic [3:0]  r_pr1     [4];
    logic [3:0]  r_pr2     [4];
    logic [3:0]  r_prd     [4];

    logic        w_ds_stall, w_rt_valid;
    logic        w_fl_take, w_ds_take, w_is_take, w_cm_take;
    logic [1:0]  w_fl_age;
    logic [1:0]  w_age [4];
    logic [3:0]  w_keep;
    logic [1:0]  w_head_nx, w_tail_nx;
    logic [2:0]  w_count_nx;
    logic [3:0]  w_valid_nx, w_issue_nx, w_commit_nx;

    // Full stalls dispatch even if the head retires this cycle (no bypass).
    assign w_ds_stall = (r_count == 3'd4);
    assign w_rt_valid = r_valid[r_head] & r_commit[r_head];
    assign w_fl_take  = rob.fl_valid & r_valid[rob.fl_rob_index];
    assign w_fl_age   = rob.fl_rob_index - r_head;
    assign w_ds_take  = rob.ds_valid & ~w_ds_stall & ~rob.fl_valid;

    // Survivors of a flush: every entry no younger than the mispredicting one.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_age[i]  = 2'(i) - r_head;
            w_keep[i] = ~w_fl_take | (w_age[i] <= w_fl_age);
        end
    end

    assign w_is_take = rob.is_valid & r_valid[rob.is_rob_index] & w_keep[rob.is_rob_index];
    assign w_cm_take = rob.cm_valid & r_valid[rob.cm_rob_index] & r_issue[rob.cm_rob_index]
                     & w_keep[rob.cm_rob_index];

    // Next-state of pointers, occupancy and per-entry status bits.
    always_comb begin
        w_valid_nx  = r_valid  & w_keep;
        w_issue_nx  = r_issue  & w_keep;
        w_commit_nx = r_commit & w_keep;
        if (w_is_take) w_issue_nx[rob.is_rob_index]  = 1'b1;
        if (w_cm_take) w_commit_nx[rob.cm_rob_index] = 1'b1;
        if (w_rt_valid) begin
            w_valid_nx[r_head]  = 1'b0;
            w_issue_nx[r_head]  = 1'b0;
            w_commit_nx[r_head] = 1'b0;
        end
        if (w_ds_take) begin
            w_valid_nx[r_tail]  = 1'b1;
            w_issue_nx[r_tail]  = 1'b0;
            w_commit_nx[r_tail] = 1'b0;
        end
        w_head_nx  = r_head + {1'b0, w_rt_valid};
        w_tail_nx  = w_fl_take ? (rob.fl_rob_index + 2'd1) : (r_tail + {1'b0, w_ds_take});
        w_count_nx = (w_fl_take ? ({1'b0, w_fl_age} + 3'd1) : r_count)
                   + {2'b00, w_ds_take} - {2'b00, w_rt_valid};
    end

    // State and field registers; only gwe-qualified edges change anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head   <= 2'd0;
            r_tail   <= 2'd0;
            r_count  <= 3'd0;
            r_valid  <= 4'b0000;
            r_issue  <= 4'b0000;
            r_commit <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_insn[i]    <= 16'h0000;
                r_pc[i]      <= 16'h0000;
                r_pc_pred[i] <= 16'h0000;
                r_pr1[i]     <= 4'h0;
                r_pr2[i]     <= 4'h0;
                r_prd[i]     <= 4'h0;
            end
        end else if (rob.gwe) begin
            r_head   <= w_head_nx;
            r_tail   <= w_tail_nx;
            r_count  <= w_count_nx;
            r_valid  <= w_valid_nx;
            r_issue  <= w_issue_nx;
            r_commit <= w_commit_nx;
            if (w_ds_take) begin
                r_insn[r_tail]    <= rob.ds_insn;
                r_pc[r_tail]      <= rob.ds_pc;
                r_pc_pred[r_tail] <= rob.ds_pc_pred;
                r_pr1[r_tail]     <= rob.ds_pr1;
                r_pr2[r_tail]     <= rob.ds_pr2;
                r_prd[r_tail]     <= rob.ds_prd;
            end
        end
    end

    assign rob.ds_stall     = w_ds_stall;
    assign rob.iq_valid     = r_valid;
    assign rob.iq_issue     = r_issue;
    assign rob.iq_commit    = r_commit;
    assign rob.iq_rd        = r_head;
    assign rob.iq_count     = r_count;
    assign rob.rt_valid     = w_rt_valid;
    assign rob.rt_insn      = r_insn[r_head];
    assign rob.rt_pc        = r_pc[r_head];
    assign rob.rt_prd       = r_prd[r_head];
    assign rob.rt_rob_index = r_head;

    assign rob.iq0_insn = r_insn[0];       assign rob.iq1_insn = r_insn[1];
    assign rob.iq2_insn = r_insn[2];       assign rob.iq3_insn = r_insn[3];
    assign rob.iq0_pc = r_pc[0];           assign rob.iq1_pc = r_pc[1];
    assign rob.iq2_pc = r_pc[2];           assign rob.iq3_pc = r_pc[3];
    assign rob.iq0_pc_pred = r_pc_pred[0]; assign rob.iq1_pc_pred = r_pc_pred[1];
    assign rob.iq2_pc_pred = r_pc_pred[2]; assign rob.iq3_pc_pred = r_pc_pred[3];
    assign rob.iq0_pr1 = r_pr1[0];         assign rob.iq1_pr1 = r_pr1[1];
    assign rob.iq2_pr1 = r_pr1[2];         assign rob.iq3_pr1 = r_pr1[3];
    assign rob.iq0_pr2 = r_pr2[0];         assign rob.iq1_pr2 = r_pr2[1];
    assign rob.iq2_pr2 = r_pr2[2];         assign rob.iq3_pr2 = r_pr2[3];
    assign rob.iq0_prd = r_prd[0];         assign rob.iq1_prd = r_prd[1];
    assign rob.iq2_prd = r_prd[2];         assign rob.iq3_prd = r_prd[3];
endmodule

// File: tb/tb_lc4_reorder_buffer.sv
// Self-checking bench for lc4_reorder_buffer: directed scenarios followed by
// randomized traffic, all compared against an age-ordered queue model.
module tb_lc4_reorder_buffer;
    logic clk;
    logic rst;

    lc4_reorder_buffer_if rob ();

    lc4_reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rob (rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT per-entry fields gathered into arrays for looping
    logic [15:0] d_insn [4];
    logic [15:0] d_pc   [4];
    logic [15:0] d_pcp  [4];
    logic [11:0] d_pr   [4];
    assign d_insn[0] = rob.iq0_insn; assign d_insn[1] = rob.iq1_insn;
    assign d_insn[2] = rob.iq2_insn; assign d_insn[3] = rob.iq3_insn;
    assign d_pc[0] = rob.iq0_pc;     assign d_pc[1] = rob.iq1_pc;
    assign d_pc[2] = rob.iq2_pc;     assign d_pc[3] = rob.iq3_pc;
    assign d_pcp[0] = rob.iq0_pc_pred; assign d_pcp[1] = rob.iq1_pc_pred;
    assign d_pcp[2] = rob.iq2_pc_pred; assign d_pcp[3] = rob.iq3_pc_pred;
    assign d_pr[0] = {rob.iq0_pr1, rob.iq0_pr2, rob.iq0_prd};
    assign d_pr[1] = {rob.iq1_pr1, rob.iq1_pr2, rob.iq1_prd};
    assign d_pr[2] = {rob.iq2_pr1, rob.iq2_pr2, rob.iq2_prd};
    assign d_pr[3] = {rob.iq3_pr1, rob.iq3_pr2, rob.iq3_prd};

    // Reference model: in-flight instructions oldest-first, plus slot storage
    typedef struct {
        logic [1:0] idx;
        bit         iss;
        bit         done;
    } ent_t;
    ent_t        mq[$];
    int          mhead;
    logic [15:0] m_insn [4];
    logic [15:0] m_pc   [4];
    logic [15:0] m_pcp  [4];
    logic [11:0] m_pr   [4];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mhead = 0;
        for (int i = 0; i < 4; i++) begin
            m_insn[i] = '0; m_pc[i] = '0; m_pcp[i] = '0; m_pr[i] = '0;
        end
    endtask

    function automatic int find_pos(input logic [1:0] idx);
        for (int p = 0; p < mq.size(); p++)
            if (mq[p].idx == idx) return p;
        return -1;
    endfunction

    // Apply one clock edge of behaviour to the model, using current inputs
    task automatic model_update();
        int  n, fp, ip, cp, t;
        bit  rt, ds, is_ok, cm_ok;
        if (!rob.gwe) return;
        n  = mq.size();
        rt = (n > 0) && mq[0].done;
        fp = rob.fl_valid ? find_pos(rob.fl_rob_index) : -1;
        ip = rob.is_valid ? find_pos(rob.is_rob_index) : -1;
        cp = rob.cm_valid ? find_pos(rob.cm_rob_index) : -1;
        ds = rob.ds_valid && (n < 4) && !rob.fl_valid;
        is_ok = (ip >= 0) && (fp < 0 || ip <= fp);
        cm_ok = (cp >= 0) && mq[cp].iss && (fp < 0 || cp <= fp);
        t = (mhead + n) % 4;
        if (is_ok) mq[ip].iss = 1'b1;
        if (cm_ok) mq[cp].done = 1'b1;
        if (fp >= 0)
            while (mq.size() > fp + 1) void'(mq.pop_back());
        if (rt) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % 4;
        end
        if (ds) begin
            ent_t e;
            e.idx = 2'(t); e.iss = 1'b0; e.done = 1'b0;
            mq.push_back(e);
            m_insn[t] = rob.ds_insn;
            m_pc[t]   = rob.ds_pc;
            m_pcp[t]  = rob.ds_pc_pred;
            m_pr[t]   = {rob.ds_pr1, rob.ds_pr2, rob.ds_prd};
        end
    endtask

    task automatic compare_all();
        logic [3:0] ev, ei, ec;
        ev = '0; ei = '0; ec = '0;
        foreach (mq[p]) begin
            ev[mq[p].idx] = 1'b1;
            ei[mq[p].idx] = mq[p].iss;
            ec[mq[p].idx] = mq[p].done;
        end
        chk("iq_valid",  32'(rob.iq_valid),  32'(ev));
        chk("iq_issue",  32'(rob.iq_issue),  32'(ei));
        chk("iq_commit", 32'(rob.iq_commit), 32'(ec));
        chk("iq_rd",     32'(rob.iq_rd),     32'(mhead));
        chk("iq_count",  32'(rob.iq_count),  32'(mq.size()));
        chk("ds_stall",  32'(rob.ds_stall),  32'(mq.size() == 4));
        chk("rt_valid",  32'(rob.rt_valid),  32'((mq.size() > 0) && mq[0].done));
        chk("rt_index",  32'(rob.rt_rob_index), 32'(mhead));
        chk("rt_insn",   32'(rob.rt_insn),   32'(m_insn[mhead]));
        chk("rt_pc",     32'(rob.rt_pc),     32'(m_pc[mhead]));
        chk("rt_prd",    32'(rob.rt_prd),    32'(m_pr[mhead][3:0]));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("insn%0d", i), 32'(d_insn[i]), 32'(m_insn[i]));
            chk($sformatf("pc%0d", i),   32'(d_pc[i]),   32'(m_pc[i]));
            chk($sformatf("pcp%0d", i),  32'(d_pcp[i]),  32'(m_pcp[i]));
            chk($sformatf("pr%0d", i),   32'(d_pr[i]),   32'(m_pr[i]));
        end
    endtask

    task automatic clr_in();
        rob.gwe = 1'b1;
        rob.ds_valid = 1'b0; rob.is_valid = 1'b0; rob.cm_valid = 1'b0; rob.fl_valid = 1'b0;
        rob.is_rob_index = 2'd0; rob.cm_rob_index = 2'd0; rob.fl_rob_index = 2'd0;
    endtask

    task automatic set_ds(input logic [15:0] insn);
        rob.ds_valid   = 1'b1;
        rob.ds_insn    = insn;
        rob.ds_pc      = insn ^ 16'h3000;
        rob.ds_pc_pred = insn + 16'h0010;
        rob.ds_pr1     = insn[3:0];
        rob.ds_pr2     = ~insn[3:0];
        rob.ds_prd     = insn[3:0] + 4'd1;
    endtask

    // One clock edge: model follows the same inputs, outputs sampled after the edge
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rob.ds_insn = '0; rob.ds_pc = '0; rob.ds_pc_pred = '0;
        rob.ds_pr1 = '0; rob.ds_pr2 = '0; rob.ds_prd = '0;
        clr_in();
        model_reset();
        rst = 1'b1;
        #12;
        compare_all();
        chk("rst_count", 32'(rob.iq_count), 32'd0);
        chk("rst_stall", 32'(rob.ds_stall), 32'd0);
        rst = 1'b0;

        // Fill with 0x1000..0x1003, then a refused fifth dispatch
        for (int k = 0; k < 4; k++) begin
            clr_in(); set_ds(16'h1000 + 16'(k)); step();
        end
        chk("full_count", 32'(rob.iq_count), 32'd4);
        chk("full_stall", 32'(rob.ds_stall), 32'd1);
        chk("full_valid", 32'(rob.iq_valid), 32'hF);
        clr_in(); set_ds(16'h1FFF); step();
        chk("refused_count", 32'(rob.iq_count), 32'd4);
        chk("refused_insn0", 32'(rob.iq0_insn), 32'h1000);

        // Out-of-order completion: index 1 finishes before index 0
        clr_in(); rob.is_valid = 1; rob.is_rob_index = 2'd1; step();
        clr_in(); rob.cm_valid = 1; rob.cm_rob_index = 2'd1; step();
        chk("ooo_issue1",  32'(rob.iq_issue[1]),  32'd1);
        chk("ooo_commit1", 32'(rob.iq_commit[1]), 32'd1);
        chk("ooo_rt",      32'(rob.rt_valid),     32'd0);
        clr_in(); rob.is_valid = 1; rob.is_rob_index = 2'd0; step();
        clr_in(); rob.cm_valid = 1; rob.cm_rob_index = 2'd0; step();
        chk("head_rt", 32'(rob.rt_valid), 32'd1);
        clr_in(); step();
        clr_in(); step();
        chk("ret_rd",    32'(rob.iq_rd),    32'd2);
        chk("ret_count", 32'(rob.iq_count), 32'd2);

        // Wrap-around: two more dispatches, retire 2, 3, 0
        clr_in(); set_ds(16'h1004); step();
        clr_in(); set_ds(16'h1005); step();
        clr_in(); rob.is_valid = 1; rob.is_rob_index = 2'd2; step();
        clr_in(); rob.cm_valid = 1; rob.cm_rob_index = 2'd2;
        rob.is_valid = 1; rob.is_rob_index = 2'd3; step();
        clr_in(); rob.cm_valid = 1; rob.cm_rob_index = 2'd3;
        rob.is_valid = 1; rob.is_rob_index = 2'd0; step();
        clr_in(); rob.cm_valid = 1; rob.cm_rob_index = 2'd0; step();
        clr_in(); step();
        chk("wrap_rd",    32'(rob.iq_rd),    32'd1);
        chk("wrap_valid", 32'(rob.iq_valid), 32'b0010);
        chk("wrap_insn1", 32'(rob.iq1_insn), 32'h1005);
        chk("wrap_pc1",   32'(rob.iq1_pc),   32'h2005);

        // Build head = 2 with four valid entries and entry 0 issued
        clr_in(); set_ds(16'h1006); rob.is_valid = 1; rob.is_rob_index = 2'd1; step();
        clr_in(); set_ds(16'h1007); rob.cm_valid = 1; rob.cm_rob_index = 2'd1; step();
        clr_in(); set_ds(16'h1008); step();
        clr_in(); set_ds(16'h1009); rob.is_valid = 1; rob.is_rob_index = 2'd0; step();
        chk("pre_fl_rd",    32'(rob.iq_rd),    32'd2);
        chk("pre_fl_count", 32'(rob.iq_count), 32'd4);
        // Flush at 3 with a same-cycle dispatch and completion of a squashed entry
        clr_in(); rob.fl_valid = 1; rob.fl_rob_index = 2'd3;
        set_ds(16'h10AA); rob.cm_valid = 1; rob.cm_rob_index = 2'd0; step();
        chk("fl_valid",  32'(rob.iq_valid),  32'b1100);
        chk("fl_count",  32'(rob.iq_count),  32'd2);
        chk("fl_commit", 32'(rob.iq_commit), 32'b0000);
        clr_in(); set_ds(16'h100B); step();
        chk("fl_tail", 32'(rob.iq_valid), 32'b1101);

        // Retire + dispatch + issue in one edge, first with gwe low
        clr_in(); rob.is_valid = 1; rob.is_rob_index = 2'd2; step();
        clr_in(); rob.cm_valid = 1; rob.cm_rob_index = 2'd2; step();
        clr_in(); set_ds(16'h100C); rob.is_valid = 1; rob.is_rob_index = 2'd3;
        rob.gwe = 1'b0; step();
        chk("gwe0_count", 32'(rob.iq_count), 32'd3);
        chk("gwe0_rd",    32'(rob.iq_rd),    32'd2);
        rob.gwe = 1'b1; step();
        chk("same_count", 32'(rob.iq_count), 32'd3);
        chk("same_valid", 32'(rob.iq_valid), 32'b1011);
        chk("same_issue", 32'(rob.iq_issue), 32'b1000);
        chk("same_rd",    32'(rob.iq_rd),    32'd3);

        // Asynchronous reset mid-stream with three entries valid
        clr_in();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 32'(rob.iq_valid), 32'd0);
        chk("arst_count", 32'(rob.iq_count), 32'd0);
        compare_all();
        #2 rst = 1'b0;
        clr_in(); set_ds(16'h1ABC); step();
        chk("post_rst_valid", 32'(rob.iq_valid), 32'b0001);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            clr_in();
            rob.gwe = ($urandom_range(9) != 0);
            if ($urandom_range(1) == 1) set_ds(16'($urandom()));
            rob.is_valid = ($urandom_range(1) == 1);
            rob.cm_valid = ($urandom_range(1) == 1);
            rob.fl_valid = ($urandom_range(9) == 0);
            if (mq.size() > 0 && $urandom_range(3) != 0)
                rob.is_rob_index = mq[$urandom_range(mq.size() - 1)].idx;
            else
                rob.is_rob_index = 2'($urandom_range(3));
            if (mq.size() > 0 && $urandom_range(3) != 0)
                rob.cm_rob_index = mq[$urandom_range(mq.size() - 1)].idx;
            else
                rob.cm_rob_index = 2'($urandom_range(3));
            if (mq.size() > 0 && $urandom_range(3) != 0)
                rob.fl_rob_index = mq[$urandom_range(mq.size() - 1)].idx;
            else
                rob.fl_rob_index = 2'($urandom_range(3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
